real_clk_core: RTL and testbench
================================

REAL_CLK_CORE -- requirements
Module: real_clk_core

Interface
REQ-001 Parameter CLK_DIV, default 100000000, clk cycles per one-second tick, legal range 2..2^27.
REQ-002 Parameter HOUR_12, default 0, 1 selects the 12-hour view on hours_out/pm.
REQ-003 Port clk  input  1  single system clock, all logic on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port run  input  1  1 lets time advance; 0 freezes counters and prescaler.
REQ-006 Port load  input  1  one-cycle write strobe.
REQ-007 Port addrs  input  2  write target: 00 seconds, 01 minutes, 10 hours, 11 alarm slot.
REQ-008 Port data_in  input  6  binary write value.
REQ-009 Port alarm_ack  input  1  clears the alarm flag.
REQ-010 Port tick  output  1  one-cycle pulse per elapsed second.
REQ-011 Port q_seconds  output  6  binary seconds, 0..59.
REQ-012 Port q_minutes  output  6  binary minutes, 0..59.
REQ-013 Port hours_out  output  5  0..23, or 1..12 when HOUR_12=1.
REQ-014 Port pm  output  1  1 for internal hours 12..23, else 0.
REQ-015 Port alarm  output  1  latched alarm flag.

Function
REQ-016 Prescaler counts 0..CLK_DIV-1 while run=1, wraps to 0, and asserts tick in the cycle it wraps.
REQ-017 On tick, seconds increment; 59 wraps to 0 with carry to minutes; minutes 59 wraps to 0 with carry to hours; hours 23 wraps to 0.
REQ-018 All counters update in the cycle tick is high, so the outputs show the new time in the next cycle (latency 1).
REQ-019 Hours are held internally as 0..23; HOUR_12=1 maps 0 to 12, 13..23 to 1..11, and 1..12 unchanged; pm is valid in both modes.
REQ-020 load=1 with in-range data writes the addressed field on that edge; range is 0..59 for seconds and minutes, 0..23 for hours.
REQ-021 load=1 with out-of-range data is ignored: no field changes and the tick is still processed normally.
REQ-022 An accepted load takes priority over a same-cycle tick: the tick is dropped, no field advances, and no carry is generated.
REQ-023 An accepted load to addrs 00 also clears the prescaler to 0, so the next tick occurs exactly CLK_DIV cycles later.
REQ-024 With run=0, tick stays 0 and loads are still accepted.
REQ-025 Alarm is described under Configuration; without it, addrs 11 loads are ignored and alarm=0.

Reset
REQ-026 On reset=1 at a clock edge: prescaler, seconds and minutes go to 0, internal hours go to 0, tick=0, alarm=0, and both alarm registers go to 0.
REQ-027 After reset: hours_out=0 and pm=0 when HOUR_12=0; hours_out=12 and pm=0 when HOUR_12=1.
REQ-028 Reset overrides load, tick and alarm_ack in the same cycle.

Configuration
REQ-029 The macro REAL_CLK_ALARM_EN compiles the alarm in.
REQ-030 With REAL_CLK_ALARM_EN, addrs 11 writes the alarm registers alternately: first the alarm hour (0..23), then the alarm minute (0..59). A one-bit pointer, cleared by reset, selects the register and toggles on each accepted write.
REQ-031 With REAL_CLK_ALARM_EN, alarm sets in the cycle after a tick makes the time equal alarm hour:alarm minute:00. It stays set until alarm_ack=1. If a set and an ack happen in the same cycle, the set wins.
REQ-032 Without REAL_CLK_ALARM_EN, no alarm registers exist, alarm is tied to 0 and alarm_ack is ignored.

Structure
REQ-033 A shared package holds SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, the address constants ADDR_SEC, ADDR_MIN, ADDR_HOUR and ADDR_ALARM, and the field widths.
REQ-034 The prescaler is the sub-module rtc_prescaler (CLK_DIV, run, clear in; tick out). It is instantiated once; all other logic is in real_clk_core.

Verification
REQ-035 Run all scenarios with CLK_DIV=4, HOUR_12=0 and REAL_CLK_ALARM_EN defined unless a scenario says otherwise.
REQ-036 Reset, then run=1 for 12 cycles -> tick at cycles 4, 8 and 12; q_seconds reads 3 afterwards.
REQ-037 Load hours=23, minutes=59, seconds=59, then one tick -> time reads 00:00:00 with no glitch in between.
REQ-038 Load seconds with data_in=60 -> ignored, q_seconds unchanged; load hours=25 -> ignored.
REQ-039 Load minutes on the same edge as a tick -> minutes take the loaded value and seconds do not advance. Load seconds=10 -> next tick comes exactly 4 cycles later.
REQ-040 HOUR_12=1: internal hours 0, 12 and 13 -> hours_out/pm read 12/0, 12/1 and 1/1.
REQ-041 Alarm at 07:30; time 07:29:59 plus one tick -> alarm=1 the next cycle, stays 1 across later ticks, and clears the cycle after alarm_ack. Without REAL_CLK_ALARM_EN -> alarm stays 0.

Source files
------------

// File: rtl/real_clk_pkg.sv
// Shared constants and helpers for the real-time clock core.
// Field limits, write addresses and the 12-hour view mapping.
package real_clk_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 6;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  localparam logic [ADDR_W-1:0] ADDR_SEC   = 2'b00;
  localparam logic [ADDR_W-1:0] ADDR_MIN   = 2'b01;
  localparam logic [ADDR_W-1:0] ADDR_HOUR  = 2'b10;
  localparam logic [ADDR_W-1:0] ADDR_ALARM = 2'b11;

  function automatic logic [HOUR_W-1:0] to_12h(
    input logic [HOUR_W-1:0] h
  );
    logic [HOUR_W-1:0] r;
    r = h;
    if (h == '0)
      r = 5'd12;
    else if (h > 5'd12)
      r = h - 5'd12;
    return r;
  endfunction

endpackage

// File: rtl/real_clk_core_prescaler.sv
// One-second prescaler: counts 0..CLK_DIV-1 while run is high.
// tick is high in the cycle the count wraps back to zero.
module rtc_prescaler #(
  parameter int unsigned CLK_DIV = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign tick    = run & at_last & ~clear;

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (clear)
      cnt_q <= '0;
    else if (run)
      cnt_q <= at_last ? '0 : cnt_q + CW'(1);
  end

endmodule

// File: rtl/real_clk_core.sv
// Binary time-of-day clock with loadable fields and optional alarm.
// Alarm logic is compiled in with REAL_CLK_ALARM_EN.
module real_clk_core
  import real_clk_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000000,
  parameter bit          HOUR_12 = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              load,
  input  logic [ADDR_W-1:0] addrs,
  input  logic [DATA_W-1:0] data_in,
  input  logic              alarm_ack,
  output logic              tick,
  output logic [SEC_W-1:0]  q_seconds,
  output logic [MIN_W-1:0]  q_minutes,
  output logic [HOUR_W-1:0] hours_out,
  output logic              pm,
  output logic              alarm
);

  logic [SEC_W-1:0]  sec_q;
  logic [MIN_W-1:0]  min_q;
  logic [HOUR_W-1:0] hr_q;

  logic [SEC_W-1:0]  sec_nx;
  logic [MIN_W-1:0]  min_nx;
  logic [HOUR_W-1:0] hr_nx;
  logic              sec_wrap;
  logic              min_wrap;

  logic in_range;
  logic load_ok;
  logic ptick;
  logic step;
  logic al_ptr;

  rtc_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clear (load_ok && (addrs == ADDR_SEC)),
    .tick  (ptick)
  );

  // An accepted load wins over a same-cycle tick.
  assign load_ok = load & in_range;
  assign step    = ptick & ~load_ok;
  assign tick    = step;

  always_comb begin
    in_range = 1'b0;
    case (addrs)
      ADDR_SEC:   in_range = (data_in <= SEC_MAX);
      ADDR_MIN:   in_range = (data_in <= MIN_MAX);
      ADDR_HOUR:  in_range = (data_in <= {1'b0, HOUR_MAX});
`ifdef REAL_CLK_ALARM_EN
      ADDR_ALARM: in_range = al_ptr ?
                    (data_in <= MIN_MAX) :
                    (data_in <= {1'b0, HOUR_MAX});
`else
      ADDR_ALARM: in_range = 1'b0;
`endif
      default:    in_range = 1'b0;
    endcase
  end

  always_comb begin
    sec_wrap = (sec_q == SEC_MAX);
    min_wrap = (min_q == MIN_MAX);
    sec_nx   = sec_wrap ? '0 : sec_q + 6'd1;
    min_nx   = min_q;
    hr_nx    = hr_q;
    if (sec_wrap)
      min_nx = min_wrap ? '0 : min_q + 6'd1;
    if (sec_wrap && min_wrap)
      hr_nx = (hr_q == HOUR_MAX) ? '0 : hr_q + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q <= '0;
      min_q <= '0;
      hr_q  <= '0;
    end else if (load_ok) begin
      case (addrs)
        ADDR_SEC:  sec_q <= data_in;
        ADDR_MIN:  min_q <= data_in;
        ADDR_HOUR: hr_q  <= data_in[HOUR_W-1:0];
        default:   ;
      endcase
    end else if (step) begin
      sec_q <= sec_nx;
      min_q <= min_nx;
      hr_q  <= hr_nx;
    end
  end

`ifdef REAL_CLK_ALARM_EN
  logic [HOUR_W-1:0] al_hr_q;
  logic [MIN_W-1:0]  al_min_q;
  logic              alarm_q;
  logic              al_hit;

  // Match on the time this tick is about to produce.
  assign al_hit = step && (sec_nx == '0) &&
                  (min_nx == al_min_q) &&
                  (hr_nx == al_hr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      al_hr_q  <= '0;
      al_min_q <= '0;
      al_ptr   <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      if (load_ok && (addrs == ADDR_ALARM)) begin
        al_ptr <= ~al_ptr;
        if (al_ptr)
          al_min_q <= data_in;
        else
          al_hr_q <= data_in[HOUR_W-1:0];
      end
      if (al_hit)
        alarm_q <= 1'b1;
      else if (alarm_ack)
        alarm_q <= 1'b0;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_ack;

  assign al_ptr     = 1'b0;
  assign alarm      = 1'b0;
  assign unused_ack = alarm_ack;
`endif

  assign q_seconds = sec_q;
  assign q_minutes = min_q;
  assign hours_out = HOUR_12 ? to_12h(hr_q) : hr_q;
  assign pm        = (hr_q >= 5'd12);

endmodule

// File: tb/tb_real_clk_core.sv
// Directed bench for real_clk_core with CLK_DIV=4.
// A second instance with HOUR_12=1 shares the same stimulus.
module tb_real_clk_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       load;
  logic [1:0] addrs;
  logic [5:0] data_in;
  logic       alarm_ack;

  logic       tick, pm, alarm;
  logic [5:0] q_seconds, q_minutes;
  logic [4:0] hours_out;

  logic       tick12, pm12, alarm12;
  logic [5:0] sec12, min12;
  logic [4:0] hours12;

  int total = 0;
  int fails = 0;
  bit al_en;

  always #5 clk = ~clk;

  real_clk_core #(.CLK_DIV(4), .HOUR_12(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .load      (load),
    .addrs     (addrs),
    .data_in   (data_in),
    .alarm_ack (alarm_ack),
    .tick      (tick),
    .q_seconds (q_seconds),
    .q_minutes (q_minutes),
    .hours_out (hours_out),
    .pm        (pm),
    .alarm     (alarm)
  );

  real_clk_core #(.CLK_DIV(4), .HOUR_12(1'b1)) dut12 (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .load      (load),
    .addrs     (addrs),
    .data_in   (data_in),
    .alarm_ack (alarm_ack),
    .tick      (tick12),
    .q_seconds (sec12),
    .q_minutes (min12),
    .hours_out (hours12),
    .pm        (pm12),
    .alarm     (alarm12)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [5:0] d);
    addrs   = a;
    data_in = d;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int h,
                          input int m, input int s);
    chk({tag, "_h"}, 32'(hours_out), 32'(h));
    chk({tag, "_m"}, 32'(q_minutes), 32'(m));
    chk({tag, "_s"}, 32'(q_seconds), 32'(s));
  endtask

  initial begin
`ifdef REAL_CLK_ALARM_EN
    al_en = 1'b1;
`else
    al_en = 1'b0;
`endif
    reset = 1'b1; run = 1'b0; load = 1'b0;
    addrs = 2'b00; data_in = 6'd0; alarm_ack = 1'b0;
    step(); step();
    reset = 1'b0;

    chk_time("rst", 0, 0, 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_pm", 32'(pm), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_h12", 32'(hours12), 12);
    chk("rst_pm12", 32'(pm12), 0);

    // 12 run cycles: ticks in cycles 4, 8, 12
    run = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      chk($sformatf("tick_c%0d", i), 32'(tick),
          32'((i % 4) == 0));
      step();
    end
    chk("sec_after12", 32'(q_seconds), 3);
    run = 1'b0;

    // Full rollover 23:59:59 -> 00:00:00
    wr(2'b10, 6'd23);
    wr(2'b01, 6'd59);
    wr(2'b00, 6'd59);
    chk_time("ld_max", 23, 59, 59);
    chk("pm23", 32'(pm), 1);
    chk("h12_23", 32'(hours12), 11);
    run = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk_time($sformatf("hold_c%0d", i), 23, 59, 59);
      chk($sformatf("notick_c%0d", i), 32'(tick), 0);
      step();
    end
    chk("roll_tick", 32'(tick), 1);
    step();
    run = 1'b0;
    chk_time("roll", 0, 0, 0);
    chk("roll_pm", 32'(pm), 0);
    chk("roll_h12", 32'(hours12), 12);
    chk("roll_pm12", 32'(pm12), 0);

    // Out-of-range loads are ignored
    wr(2'b00, 6'd60);
    chk("sec60_ign", 32'(q_seconds), 0);
    wr(2'b10, 6'd25);
    chk("hr25_ign", 32'(hours_out), 0);
    wr(2'b10, 6'd24);
    chk("hr24_ign", 32'(hours_out), 0);
    wr(2'b01, 6'd63);
    chk("min63_ign", 32'(q_minutes), 0);

    // 12-hour view
    wr(2'b10, 6'd12);
    chk("h12_12", 32'(hours12), 12);
    chk("pm12_12", 32'(pm12), 1);
    chk("h24_12", 32'(hours_out), 12);
    wr(2'b10, 6'd13);
    chk("h12_13", 32'(hours12), 1);
    chk("pm12_13", 32'(pm12), 1);
    chk("h24_13", 32'(hours_out), 13);

    // Load beats a same-cycle tick
    wr(2'b00, 6'd5);
    run = 1'b1;
    step(); step(); step();
    chk("pre_ld_tick", 32'(tick), 1);
    wr(2'b01, 6'd15);
    chk("ld_min", 32'(q_minutes), 15);
    chk("ld_sec_hold", 32'(q_seconds), 5);
    step();
    chk("mid_tick", 32'(tick), 0);
    // Seconds load restarts the prescaler
    wr(2'b00, 6'd10);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("clr_c%0d", i), 32'(tick), 0);
      step();
    end
    chk("clr_tick4", 32'(tick), 1);
    step();
    chk("clr_sec", 32'(q_seconds), 11);
    run = 1'b0;

    // Alarm at 07:30
    wr(2'b11, 6'd7);
    wr(2'b11, 6'd30);
    wr(2'b10, 6'd7);
    wr(2'b01, 6'd29);
    wr(2'b00, 6'd59);
    chk("al_pre", 32'(alarm), 0);
    run = 1'b1;
    step(); step(); step();
    chk("al_tick", 32'(tick), 1);
    chk("al_wait", 32'(alarm), 0);
    step();
    chk_time("al_time", 7, 30, 0);
    chk("al_set", 32'(alarm), 32'(al_en));
    step(); step(); step(); step();
    chk("al_sec1", 32'(q_seconds), 1);
    chk("al_held", 32'(alarm), 32'(al_en));
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("al_ack", 32'(alarm), 0);
    run = 1'b0;

    // Reset overrides a same-cycle load
    reset = 1'b1;
    wr(2'b10, 6'd5);
    reset = 1'b0;
    chk_time("rst_ld", 0, 0, 0);
    chk("rst_ld_h12", 32'(hours12), 12);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
